// File: rtl/dmem_arbiter_pkg.sv
// Shared widths and FSM state encoding for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int DEF_DATA_BUS_WIDTH    = 64;
  localparam int DEF_ADDRESS_BUS_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } arbState_t;

endpackage

// File: rtl/dmem_arbiter_pick.sv
// Combinational winner select for the data-memory arbiter.
// Macro DMEM_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module dmem_arb_pick (
  input  logic [1:0] i_elig,
  input  logic       i_lastGnt,
  output logic       o_valid,
  output logic       o_gnt
);

  assign o_valid = |i_elig;

`ifdef DMEM_ARB_RR_EN
  // Contention goes to whichever port did not win last time.
  always_comb begin
    o_gnt = ~i_elig[0];
    if (i_elig == 2'b11) begin
      o_gnt = ~i_lastGnt;
    end
  end
`else
  logic w_unusedLastGnt;
  assign w_unusedLastGnt = i_lastGnt;

  always_comb begin
    o_gnt = ~i_elig[0];
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises CPU (port 0) and host loader (port 1) accesses onto one data_ram port.
// Arbitration mode is chosen by macro DMEM_ARB_RR_EN (see dmem_arb_pick).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_BUS_WIDTH    = DEF_DATA_BUS_WIDTH,
  parameter int ADDRESS_BUS_WIDTH = DEF_ADDRESS_BUS_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req0,
  input  logic                         req1,
  input  logic                         we0,
  input  logic                         we1,
  input  logic [ADDRESS_BUS_WIDTH-1:0] addr0,
  input  logic [ADDRESS_BUS_WIDTH-1:0] addr1,
  input  logic [DATA_BUS_WIDTH-1:0]    wdata0,
  input  logic [DATA_BUS_WIDTH-1:0]    wdata1,
  output logic                         ack0,
  output logic                         ack1,
  output logic [DATA_BUS_WIDTH-1:0]    rdata0,
  output logic [DATA_BUS_WIDTH-1:0]    rdata1,
  output logic                         busy,
  output logic                         mem_cs,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [ADDRESS_BUS_WIDTH-1:0] mem_addr,
  output logic [DATA_BUS_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_BUS_WIDTH-1:0]    mem_rdata
);

  arbState_t r_state;
  arbState_t w_nextState;

  logic                         r_gnt;
  logic                         r_we;
  logic [ADDRESS_BUS_WIDTH-1:0] r_addr;
  logic [DATA_BUS_WIDTH-1:0]    r_wdata;
  logic                         r_lastGnt;
  logic                         r_ack0;
  logic                         r_ack1;
  logic [DATA_BUS_WIDTH-1:0]    r_rdata0;
  logic [DATA_BUS_WIDTH-1:0]    r_rdata1;
  logic                         r_memCs;
  logic                         r_memRead;
  logic                         r_memWrite;

  logic w_elig0;
  logic w_elig1;
  logic w_pickValid;
  logic w_pickGnt;
  logic w_grant;
  logic w_finish;
  logic w_pickWe;

  // A requester still showing req during its own ack cycle is not a new request.
  assign w_elig0  = req0 & ~r_ack0;
  assign w_elig1  = req1 & ~r_ack1;
  assign w_pickWe = w_pickGnt ? we1 : we0;

  dmem_arb_pick u_pick (
    .i_elig    ({w_elig1, w_elig0}),
    .i_lastGnt (r_lastGnt),
    .o_valid   (w_pickValid),
    .o_gnt     (w_pickGnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_grant     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pickValid) begin
          w_nextState = ST_ACCESS;
          w_grant     = 1'b1;
        end
      end
      ST_ACCESS: w_nextState = ST_WAIT;
      ST_WAIT: begin
        w_nextState = ST_IDLE;
        w_finish    = 1'b1;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Strobes are registered so they sit high for exactly the ACCESS cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_lastGnt  <= 1'b1;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
      r_memCs    <= 1'b0;
      r_memRead  <= 1'b0;
      r_memWrite <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      if (w_grant) begin
        r_gnt      <= w_pickGnt;
        r_we       <= w_pickWe;
        r_addr     <= w_pickGnt ? addr1 : addr0;
        r_wdata    <= w_pickGnt ? wdata1 : wdata0;
        r_lastGnt  <= w_pickGnt;
        r_memCs    <= 1'b1;
        r_memRead  <= ~w_pickWe;
        r_memWrite <= w_pickWe;
      end
      if (r_state == ST_ACCESS) begin
        r_memCs    <= 1'b0;
        r_memRead  <= 1'b0;
        r_memWrite <= 1'b0;
      end
      if (w_finish) begin
        if (r_gnt) begin
          r_ack1 <= 1'b1;
          if (!r_we) r_rdata1 <= mem_rdata;
        end else begin
          r_ack0 <= 1'b1;
          if (!r_we) r_rdata0 <= mem_rdata;
        end
      end
    end
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign busy      = (r_state != ST_IDLE);
  assign mem_cs    = r_memCs;
  assign mem_read  = r_memRead;
  assign mem_write = r_memWrite;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule
